seq_port_alloc_pipe: RTL
========================

SEQ_PORT_ALLOC_PIPE -- requirements
Module: seq_port_alloc_pipe

Interface
REQ-001 Parameter NUM_OUT, default 4, number of output ports (index 0..NUM_OUT-1, priority order N,E,S,W for 4).
REQ-002 Parameter NUM_FLIT, default 4, flits allocated per set; also the pipeline depth.
REQ-003 Parameter MAX_COPY, default 3, maximum ports granted to one multicast flit.
REQ-004 Parameter CNT_W, default 3, width of count outputs; SHALL hold NUM_OUT.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
REQ-007 in_valid  input  1  allocation set present.
REQ-008 in_ready  output  1  set accepted when in_valid && in_ready.
REQ-009 in_fvalid  input  NUM_FLIT  per-flit valid; bit k = flit k, flit 0 highest priority.
REQ-010 in_mc  input  NUM_FLIT  per-flit multicast flag.
REQ-011 in_ppv  input  NUM_FLIT*NUM_OUT  productive port vectors; flit k at [k*NUM_OUT +: NUM_OUT].
REQ-012 in_avail  input  NUM_OUT  ports free this set.
REQ-013 out_valid  output  1  result set present.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_alloc  output  NUM_FLIT*NUM_OUT  granted ports per flit, same packing as in_ppv.
REQ-016 out_defl  output  NUM_FLIT  flit k granted a non-productive port.
REQ-017 out_drop  output  NUM_FLIT  valid flit k received no port.
REQ-018 out_avail  output  NUM_OUT  ports still free after all flits.
REQ-019 out_count  output  CNT_W  total ports granted in the set.

Function
REQ-020 Pipeline of NUM_FLIT register stages; stage k allocates flit k using the avail vector left by stage k-1; latency from accept to out_valid SHALL be exactly NUM_FLIT cycles with no stalls.
REQ-021 Global advance enable adv = ~out_valid || out_ready; all stages shift only when adv; in_ready SHALL equal adv.
REQ-022 Bubbles propagate: a stage loaded while in_valid=0 carries valid=0; out_valid SHALL rise only for accepted sets.
REQ-023 While out_valid && ~out_ready, all outputs SHALL hold stable.
REQ-024 Unicast flit (mc=0, fvalid=1): grant the lowest-index port in ppv & avail; at most one bit.
REQ-025 Multicast flit (mc=1): grant ports of ppv & avail in ascending index until MAX_COPY granted; remaining productive ports not granted.
REQ-026 Deflection: if flit valid, ppv nonzero and no productive grant, grant the first available port searching ascending from the set's captured deflection pointer with wrap at NUM_OUT; set out_defl.
REQ-027 ppv all-zero on a valid flit: no grant, no deflection, no drop (local ejection handled elsewhere).
REQ-028 No available port for a flit needing deflection: alloc zero, out_drop=1, avail unchanged.
REQ-029 Invalid flit (fvalid=0): alloc, defl, drop zero; avail passes unchanged.
REQ-030 Granted ports SHALL be cleared from the avail vector passed to the next stage; no port granted twice in one set.
REQ-031 Deflection pointer register dptr, width clog2(NUM_OUT), captured with each accepted set; increments by 1 mod NUM_OUT on each accept whose set produced... SHALL increment on every accepted set regardless of outcome.
REQ-032 out_count = popcount of all grants in the set, accumulated per stage; never exceeds NUM_OUT.

Reset
REQ-033 While reset=0 at a clock edge: all stage valids 0, out_valid 0, out_alloc/out_defl/out_drop/out_avail/out_count 0, dptr 0.
REQ-034 Reset mid-operation discards all in-flight sets; no partial set is emitted after reset release.
REQ-035 in_ready SHALL be 1 in the first cycle after reset release.

Verification (NUM_OUT=4, NUM_FLIT=4, MAX_COPY=3)
REQ-036 Unicast: fvalid=0001, ppv0=0110, avail=1111, out_ready=1 -> 4 cycles later alloc0=0010, avail=1101, count=1, defl=0.
REQ-037 Multicast cap: fvalid=0001, mc0=1, ppv0=1111, avail=1111 -> alloc0=0111, avail=1000, count=3.
REQ-038 Deflection wrap: dptr=3, fvalid=0011, ppv0=ppv1=0001, avail=0101 -> alloc0=0001; flit1 deflects to 0100 (search 3,0,1,2), defl=0010, avail=0000.
REQ-039 Drop: fvalid=0111, all ppv=0001, avail=0001 -> flit0 0001, flit1 and flit2 drop=0110, count=1.
REQ-040 Backpressure: stream 6 sets, out_ready=0 for cycles 5-8 -> in_ready=0 while full, outputs stable, all 6 results emitted in order, none lost or duplicated.
REQ-041 Reset mid-stream: reset=0 with 3 sets in flight -> out_valid=0, no stale set emitted after release, dptr=0.

Source files
------------

// File: rtl/seq_port_alloc_pipe.sv
// Pipelined output-port allocator: one flit per stage, multicast capped,
// deflection from a per-set rotating pointer, drop when nothing is free.
module seq_port_alloc_pipe #(
  parameter int NUM_OUT  = 4,
  parameter int NUM_FLIT = 4,
  parameter int MAX_COPY = 3,
  parameter int CNT_W    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FLIT-1:0]          in_fvalid,
  input  logic [NUM_FLIT-1:0]          in_mc,
  input  logic [NUM_FLIT*NUM_OUT-1:0]  in_ppv,
  input  logic [NUM_OUT-1:0]           in_avail,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FLIT*NUM_OUT-1:0]  out_alloc,
  output logic [NUM_FLIT-1:0]          out_defl,
  output logic [NUM_FLIT-1:0]          out_drop,
  output logic [NUM_OUT-1:0]           out_avail,
  output logic [CNT_W-1:0]             out_count
);

  localparam int PW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int AW = NUM_FLIT * NUM_OUT;

  typedef struct packed {
    logic                vld;
    logic [NUM_FLIT-1:0] fv;
    logic [NUM_FLIT-1:0] mc;
    logic [AW-1:0]       ppv;
    logic [AW-1:0]       alloc;
    logic [NUM_FLIT-1:0] defl;
    logic [NUM_FLIT-1:0] drop;
    logic [NUM_OUT-1:0]  avail;
    logic [PW-1:0]       dptr;
    logic [CNT_W-1:0]    cnt;
  } stage_t;

  stage_t        st  [NUM_FLIT];
  stage_t        nxt [NUM_FLIT];
  stage_t        inRec;
  logic [PW-1:0] dptr;
  logic          adv;

  // Returns {drop, defl, grant} for one flit against the live avail vector.
  function automatic logic [NUM_OUT+1:0] allocFlit(
    input logic               fv,
    input logic               mc,
    input logic [NUM_OUT-1:0] ppv,
    input logic [NUM_OUT-1:0] avail,
    input logic [PW-1:0]      ptr
  );
    logic [NUM_OUT-1:0] cand;
    logic [NUM_OUT-1:0] grant;
    logic               defl;
    logic               drop;
    logic               found;
    int                 n;
    int                 lim;
    int                 idx;
    cand  = ppv & avail;
    grant = '0;
    defl  = 1'b0;
    drop  = 1'b0;
    found = 1'b0;
    n     = 0;
    lim   = mc ? MAX_COPY : 1;
    if (fv && ppv != '0) begin
      if (cand != '0) begin
        for (int i = 0; i < NUM_OUT; i++) begin
          if (cand[i] && n < lim) begin
            grant[i] = 1'b1;
            n++;
          end
        end
      end else begin
        for (int j = 0; j < NUM_OUT; j++) begin
          idx = (int'(ptr) + j) % NUM_OUT;
          if (!found && avail[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
          end
        end
        defl = found;
        drop = !found;
      end
    end
    return {drop, defl, grant};
  endfunction

  // Applies flit k's allocation to a set record.
  function automatic stage_t stepFlit(input stage_t s, input int k);
    stage_t               r;
    logic [NUM_OUT+1:0]   a;
    logic [NUM_OUT-1:0]   g;
    logic [CNT_W-1:0]     pc;
    r  = s;
    a  = allocFlit(s.fv[k], s.mc[k], s.ppv[k*NUM_OUT +: NUM_OUT],
                   s.avail, s.dptr);
    g  = a[NUM_OUT-1:0];
    pc = '0;
    for (int i = 0; i < NUM_OUT; i++) pc = pc + CNT_W'(g[i]);
    r.alloc[k*NUM_OUT +: NUM_OUT] = g;
    r.defl[k] = a[NUM_OUT];
    r.drop[k] = a[NUM_OUT+1];
    r.avail   = s.avail & ~g;
    r.cnt     = s.cnt + pc;
    return r;
  endfunction

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Fresh set record; fields only populated for a real set.
  always_comb begin
    inRec     = '0;
    inRec.vld = in_valid;
    if (in_valid) begin
      inRec.fv    = in_fvalid;
      inRec.mc    = in_mc;
      inRec.ppv   = in_ppv;
      inRec.avail = in_avail;
      inRec.dptr  = dptr;
    end
  end

  // Each stage allocates its own flit from the previous stage's record.
  always_comb begin
    for (int k = 0; k < NUM_FLIT; k++) begin
      nxt[k] = stepFlit((k == 0) ? inRec : st[(k == 0) ? 0 : k-1], k);
    end
  end

  // Stage registers shift together; pointer advances per accepted set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_FLIT; k++) st[k] <= '0;
      dptr <= '0;
    end else if (adv) begin
      for (int k = 0; k < NUM_FLIT; k++) st[k] <= nxt[k];
      if (in_valid) begin
        dptr <= (dptr == PW'(NUM_OUT-1)) ? '0 : dptr + PW'(1);
      end
    end
  end

  assign out_valid = st[NUM_FLIT-1].vld;
  assign out_alloc = st[NUM_FLIT-1].alloc;
  assign out_defl  = st[NUM_FLIT-1].defl;
  assign out_drop  = st[NUM_FLIT-1].drop;
  assign out_avail = st[NUM_FLIT-1].avail;
  assign out_count = st[NUM_FLIT-1].cnt;

endmodule
